// File: rtl/ram_pkg.sv
// Shared types for the dual-port RAM: read-during-write policy and clear-sweep states.
package ram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear-sweep controller: walks every address once, ascending, after reset release or on clr_req.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  clr_state_e        state_r, state_s;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic              busy_r, busy_s;

  // State, sweep counter and busy flag; reset leaves the block ready to sweep from address 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= CLEAR;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
    end
  end

  // Next state: requests are only honoured in IDLE; the counter parks at 0 instead of wrapping
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = {ADDR_W{1'b0}};
        if (clr_req) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = IDLE;
          cnt_s   = {ADDR_W{1'b0}};
        end else begin
          state_s = CLEAR;
          cnt_s   = cnt_r + ADDR_ONE;
        end
      end
      default: begin
        state_s = CLEAR;
        cnt_s   = {ADDR_W{1'b0}};
      end
    endcase
    busy_s = (state_s == CLEAR);
  end

  assign busy     = busy_r;
  assign clr_we   = busy_r;
  assign clr_addr = cnt_r;

endmodule

// File: rtl/ram_dp.sv
// Dual-port RAM: port A read/write with lane enables, port B read-only, self-clearing sweep.
// Define RAM_OUT_REG_EN to add one output register stage on both ports (read latency 2).
module ram_dp
  import ram_pkg::*;
#(
  parameter int               ADDR_W   = 10,
  parameter int               DATA_W   = 8,
  parameter int               LANE_W   = 8,
  parameter rdw_mode_e        RDW_MODE = READ_FIRST,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr_req,
  output logic                       busy,
  input  logic                       a_ena,
  input  logic                       a_rd,
  input  logic                       a_wr,
  input  logic [DATA_W/LANE_W-1:0]   a_be,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [DATA_W-1:0]          a_din,
  output logic [DATA_W-1:0]          a_dout,
  output logic                       a_valid,
  input  logic                       b_ena,
  input  logic                       b_rd,
  input  logic [ADDR_W-1:0]          b_addr,
  output logic [DATA_W-1:0]          b_dout,
  output logic                       b_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NLANE = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              a_rd_s, a_wr_s, b_rd_s;
  logic [DATA_W-1:0] a_old_s, b_old_s, a_new_s, a_rdata_s, b_rdata_s;
  logic [DATA_W-1:0] a_dout1_r, b_dout1_r;
  logic              a_valid1_r, b_valid1_r;

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NLANE-1:0]  be
  );
    logic [DATA_W-1:0] w;
    for (int i = 0; i < NLANE; i++) begin
      w[i*LANE_W +: LANE_W] = be[i] ? new_w[i*LANE_W +: LANE_W] : old_w[i*LANE_W +: LANE_W];
    end
    return w;
  endfunction

  ram_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Access qualification and same-address read-during-write resolution
  always_comb begin
    a_rd_s  = a_ena & a_rd & ~busy;
    a_wr_s  = a_ena & a_wr & ~busy;
    b_rd_s  = b_ena & b_rd & ~busy;
    a_old_s = mem_r[a_addr];
    b_old_s = mem_r[b_addr];
    a_new_s = lane_merge(a_old_s, a_din, a_be);
    if ((RDW_MODE == WRITE_FIRST) && a_wr_s) begin
      a_rdata_s = a_new_s;
    end else begin
      a_rdata_s = a_old_s;
    end
    if ((RDW_MODE == WRITE_FIRST) && a_wr_s && (b_addr == a_addr)) begin
      b_rdata_s = a_new_s;
    end else begin
      b_rdata_s = b_old_s;
    end
  end

  // Array write: the sweep owns the array while busy, otherwise port A
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= CLR_VAL;
    end else if (a_wr_s) begin
      mem_r[a_addr] <= a_new_s;
    end
  end

  // First read stage: data held between reads, valid is a single-cycle pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_dout1_r  <= {DATA_W{1'b0}};
      b_dout1_r  <= {DATA_W{1'b0}};
      a_valid1_r <= 1'b0;
      b_valid1_r <= 1'b0;
    end else begin
      a_valid1_r <= a_rd_s;
      b_valid1_r <= b_rd_s;
      if (a_rd_s) a_dout1_r <= a_rdata_s;
      if (b_rd_s) b_dout1_r <= b_rdata_s;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] a_dout2_r, b_dout2_r;
  logic              a_valid2_r, b_valid2_r;

  // Optional second output stage, delaying data and valid together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_dout2_r  <= {DATA_W{1'b0}};
      b_dout2_r  <= {DATA_W{1'b0}};
      a_valid2_r <= 1'b0;
      b_valid2_r <= 1'b0;
    end else begin
      a_dout2_r  <= a_dout1_r;
      b_dout2_r  <= b_dout1_r;
      a_valid2_r <= a_valid1_r;
      b_valid2_r <= b_valid1_r;
    end
  end

  assign a_dout  = a_dout2_r;
  assign b_dout  = b_dout2_r;
  assign a_valid = a_valid2_r;
  assign b_valid = b_valid2_r;
`else
  assign a_dout  = a_dout1_r;
  assign b_dout  = b_dout1_r;
  assign a_valid = a_valid1_r;
  assign b_valid = b_valid1_r;
`endif

endmodule

// File: tb/tb_ram_dp.sv
// Self-checking bench for ram_dp: a READ_FIRST and a WRITE_FIRST instance share stimulus
// and are compared every cycle against an array-based reference model.
module tb_ram_dp;

  localparam int          AW   = 4;
  localparam int          DW   = 16;
  localparam int          N    = 16;
  localparam logic [15:0] CLRV = 16'h5AC3;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n, clr_req;
  logic          a_ena, a_rd, a_wr, b_ena, b_rd;
  logic [1:0]    a_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din;
  logic          busy_rf, busy_wf, av_rf, av_wf, bv_rf, bv_wf;
  logic [DW-1:0] ad_rf, ad_wf, bd_rf, bd_wf;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory contents, remaining sweep cycles, and expected output pipeline
  logic [DW-1:0] m_mem [N];
  int            m_cnt;
  logic [DW-1:0] ea_rf1, ea_wf1, eb_rf1, eb_wf1, ea_rf2, ea_wf2, eb_rf2, eb_wf2;
  logic          va1, vb1, va2, vb2;

  always #5 clk = ~clk;

  ram_dp #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(8), .RDW_MODE(ram_pkg::READ_FIRST), .CLR_VAL(CLRV)) dut_rf (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .busy(busy_rf),
    .a_ena(a_ena), .a_rd(a_rd), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(ad_rf), .a_valid(av_rf),
    .b_ena(b_ena), .b_rd(b_rd), .b_addr(b_addr), .b_dout(bd_rf), .b_valid(bv_rf));

  ram_dp #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(8), .RDW_MODE(ram_pkg::WRITE_FIRST), .CLR_VAL(CLRV)) dut_wf (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .busy(busy_wf),
    .a_ena(a_ena), .a_rd(a_rd), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(ad_wf), .a_valid(av_wf),
    .b_ena(b_ena), .b_rd(b_rd), .b_addr(b_addr), .b_dout(bd_wf), .b_valid(bv_wf));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic check_outputs();
    logic eb;
    eb = (m_cnt != 0);
    chk("busy_rf", {15'd0, busy_rf}, {15'd0, eb});
    chk("busy_wf", {15'd0, busy_wf}, {15'd0, eb});
    chk("a_valid_rf", {15'd0, av_rf}, {15'd0, (LAT == 2) ? va2 : va1});
    chk("a_valid_wf", {15'd0, av_wf}, {15'd0, (LAT == 2) ? va2 : va1});
    chk("b_valid_rf", {15'd0, bv_rf}, {15'd0, (LAT == 2) ? vb2 : vb1});
    chk("b_valid_wf", {15'd0, bv_wf}, {15'd0, (LAT == 2) ? vb2 : vb1});
    chk("a_dout_rf", ad_rf, (LAT == 2) ? ea_rf2 : ea_rf1);
    chk("a_dout_wf", ad_wf, (LAT == 2) ? ea_wf2 : ea_wf1);
    chk("b_dout_rf", bd_rf, (LAT == 2) ? eb_rf2 : eb_rf1);
    chk("b_dout_wf", bd_wf, (LAT == 2) ? eb_wf2 : eb_wf1);
  endtask

  task automatic model_reset();
    {ea_rf1, ea_wf1, eb_rf1, eb_wf1, ea_rf2, ea_wf2, eb_rf2, eb_wf2} = '0;
    {va1, vb1, va2, vb2} = 4'b0000;
    m_cnt = N;
  endtask

  task automatic set_idle();
    clr_req = 1'b0; a_ena = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_be = 2'b00;
    a_addr = '0; a_din = '0; b_ena = 1'b0; b_rd = 1'b0; b_addr = '0;
  endtask

  // Predict the effect of the current inputs, advance one clock, then compare
  task automatic step();
    logic          busy_m, a_rd_ok, a_wr_ok, b_rd_ok;
    logic [15:0]   old_a, old_b, merged;
    busy_m  = (m_cnt != 0);
    a_rd_ok = a_ena && a_rd && !busy_m;
    a_wr_ok = a_ena && a_wr && !busy_m;
    b_rd_ok = b_ena && b_rd && !busy_m;
    old_a   = m_mem[a_addr];
    old_b   = m_mem[b_addr];
    merged  = old_a;
    if (a_be[0]) merged[7:0]  = a_din[7:0];
    if (a_be[1]) merged[15:8] = a_din[15:8];
    ea_rf2 = ea_rf1; ea_wf2 = ea_wf1; eb_rf2 = eb_rf1; eb_wf2 = eb_wf1;
    va2 = va1; vb2 = vb1;
    va1 = a_rd_ok; vb1 = b_rd_ok;
    if (a_rd_ok) begin
      ea_rf1 = old_a;
      ea_wf1 = a_wr_ok ? merged : old_a;
    end
    if (b_rd_ok) begin
      eb_rf1 = old_b;
      eb_wf1 = (a_wr_ok && (b_addr == a_addr)) ? merged : old_b;
    end
    if (busy_m) begin
      m_mem[N - m_cnt] = CLRV;
      m_cnt--;
    end else begin
      if (a_wr_ok) m_mem[a_addr] = merged;
      if (clr_req) m_cnt = N;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      set_idle();
      a_ena = 1'b1; a_rd = 1'b1; a_addr = AW'(i);
      b_ena = 1'b1; b_rd = 1'b1; b_addr = AW'(N - 1 - i);
      step();
    end
    set_idle();
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_mem[i] = 16'h0000;
    set_idle();
    model_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_outputs();
    @(posedge clk); @(posedge clk); #1;
    check_outputs();
    reset_n = 1'b1;

    // Power-on sweep: busy for N cycles, then every word reads the clear value
    for (int i = 0; i < N; i++) step();
    step();
    read_all();
    chk("sweep_word15_a", ad_rf, CLRV);

    // Lane-0 write then port B read of the same address
    set_idle(); a_ena = 1'b1; a_wr = 1'b1; a_be = 2'b01; a_addr = 4'd3; a_din = 16'h00A5; step();
    set_idle(); b_ena = 1'b1; b_rd = 1'b1; b_addr = 4'd3; step();
    set_idle(); step();
    chk("b_read_after_write", bd_wf, 16'h5AA5);

    // Same-address write with simultaneous reads on both ports
    set_idle(); a_ena = 1'b1; a_wr = 1'b1; a_be = 2'b11; a_addr = 4'd5; a_din = 16'h1234; step();
    set_idle(); a_ena = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_be = 2'b01; a_addr = 4'd5; a_din = 16'hABCD;
    b_ena = 1'b1; b_rd = 1'b1; b_addr = 4'd5; step();
    set_idle(); step();
    chk("rdw_b_read_first", bd_rf, 16'h1234);
    chk("rdw_b_write_first", bd_wf, 16'h12CD);
    chk("rdw_a_read_first", ad_rf, 16'h1234);
    set_idle(); b_ena = 1'b1; b_rd = 1'b1; b_addr = 4'd5; step();
    set_idle(); step();
    chk("rdw_after_read", bd_rf, 16'h12CD);

    // Randomised traffic with frequent address collisions and occasional clear requests
    for (int i = 0; i < 300; i++) begin
      a_ena   = ($urandom_range(0, 3) != 0);
      a_rd    = $urandom_range(0, 1) != 0;
      a_wr    = $urandom_range(0, 1) != 0;
      a_be    = 2'($urandom_range(0, 3));
      a_addr  = AW'($urandom_range(0, N - 1));
      a_din   = 16'($urandom);
      b_ena   = ($urandom_range(0, 3) != 0);
      b_rd    = $urandom_range(0, 1) != 0;
      b_addr  = ($urandom_range(0, 1) != 0) ? a_addr : AW'($urandom_range(0, N - 1));
      clr_req = ($urandom_range(0, 79) == 0);
      step();
    end
    set_idle();
    for (int i = 0; i < N + 2; i++) step();

    // Clear request coinciding with a read; write and a second request during busy are ignored
    set_idle(); clr_req = 1'b1; a_ena = 1'b1; a_rd = 1'b1; a_addr = 4'd5; step();
    set_idle(); clr_req = 1'b1; a_ena = 1'b1; a_wr = 1'b1; a_be = 2'b11; a_addr = 4'd2; a_din = 16'hBEEF; step();
    set_idle();
    for (int i = 0; i < N; i++) step();
    chk("busy_low_after_sweep", {15'd0, busy_rf}, 16'h0000);
    set_idle(); a_ena = 1'b1; a_rd = 1'b1; a_addr = 4'd2; step();
    set_idle(); step();
    chk("ignored_write", ad_rf, CLRV);

    // Put known non-zero data on the outputs, then reset part-way through a sweep
    set_idle(); a_ena = 1'b1; a_wr = 1'b1; a_be = 2'b11; a_addr = 4'd9; a_din = 16'h0F0F; step();
    set_idle(); a_ena = 1'b1; a_rd = 1'b1; a_addr = 4'd9; b_ena = 1'b1; b_rd = 1'b1; b_addr = 4'd9; step();
    set_idle(); step();
    set_idle(); clr_req = 1'b1; step();
    set_idle();
    for (int i = 0; i < 7; i++) step();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) step();
    step();
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: address width; depth = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8: word width.
REQ-003 SHALL have parameter LANE_W, default 8: byte-enable lane width; DATA_W SHALL be a multiple of LANE_W; NLANE = DATA_W/LANE_W.
REQ-004 SHALL have parameter RDW_MODE, default READ_FIRST: same-address read-during-write policy, READ_FIRST or WRITE_FIRST.
REQ-005 SHALL have parameter CLR_VAL, default '0: word written by clear sweep.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 clr_req  in  1  request full-memory clear sweep.
REQ-009 busy  out  1  high while clear sweep runs.
REQ-010 a_ena, a_rd, a_wr  in  1 each  port A enable, read strobe, write strobe.
REQ-011 a_be  in  NLANE  port A per-lane write enable.
REQ-012 a_addr  in  ADDR_W; a_din  in  DATA_W  port A address, write data.
REQ-013 a_dout  out  DATA_W; a_valid  out  1  port A read data, one-cycle valid pulse.
REQ-014 b_ena, b_rd  in  1 each; b_addr  in  ADDR_W  port B (read-only) controls.
REQ-015 b_dout  out  DATA_W; b_valid  out  1  port B read data, valid pulse.

Function
REQ-016 Port A write: when a_ena&a_wr&!busy, lanes with a_be[i]=1 SHALL update; others unchanged.
REQ-017 Read: when x_ena&x_rd&!busy, x_dout SHALL hold mem[x_addr] and x_valid SHALL be 1 exactly 1 cycle later (base latency 1).
REQ-018 x_dout SHALL hold last value when no read issued; x_valid SHALL be 0 on non-read cycles.
REQ-019 Same-address A write with A or B read same cycle: READ_FIRST SHALL return old word; WRITE_FIRST SHALL return merged new word (written lanes new, unwritten lanes old).
REQ-020 Different-address simultaneous A/B accesses SHALL be independent.
REQ-021 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on reset release or clr_req in IDLE; CLEAR->IDLE after writing address 2**ADDR_W-1.
REQ-022 CLEAR SHALL write CLR_VAL to one address per cycle, ascending from 0; busy=1 for exactly 2**ADDR_W cycles.
REQ-023 During busy, port accesses SHALL be ignored: no writes, valid 0, dout held.
REQ-024 clr_req while in CLEAR SHALL be ignored (no restart, no queuing).
REQ-025 Read issued on the last IDLE cycle before a sweep SHALL still complete with valid 1 on the following cycle.
REQ-026 Address counter SHALL not wrap past 2**ADDR_W-1 in CLEAR.

Reset
REQ-027 reset_n low SHALL asynchronously set a_dout, b_dout to 0, a_valid, b_valid to 0, busy to 1, sweep counter to 0, state CLEAR.
REQ-028 Memory array SHALL not be reset directly; contents become CLR_VAL only via sweep.
REQ-029 reset_n asserted mid-sweep SHALL restart the sweep at address 0 after release.

Configuration
REQ-030 Macro RAM_OUT_REG_EN defined: extra output register stage on both ports; read latency 2, valid delayed identically, reset to 0.
REQ-031 RAM_OUT_REG_EN undefined: read latency 1 as REQ-017; no extra registers.

Structure
REQ-032 Package ram_pkg SHALL hold rdw_mode_e (READ_FIRST, WRITE_FIRST) and clr_state_e (IDLE, CLEAR).
REQ-033 Clear FSM and address counter SHALL be sub-module ram_clr_fsm (ports: clk, reset_n, clr_req, busy, clr_we, clr_addr).

Verification
REQ-034 Release reset, ADDR_W=4 -> busy high 16 cycles, then low; every address reads CLR_VAL.
REQ-035 A write 0xA5 @3 be=1, then B read @3 -> b_dout=0xA5, b_valid 1 cycle after read.
REQ-036 DATA_W=16, mem@5=0x1234, A write 0xABCD be=2'b01 @5 with B read @5 same cycle -> READ_FIRST 0x1234; WRITE_FIRST 0x12CD; subsequent read 0x12CD.
REQ-037 clr_req pulse, A write @2 and clr_req again during busy -> write ignored, sweep not restarted, busy exactly 2**ADDR_W cycles.
REQ-038 reset_n pulsed low at sweep address 7 -> outputs 0 immediately; sweep restarts at 0, full length.
REQ-039 RAM_OUT_REG_EN defined, read @1 -> data and valid appear 2 cycles after request.
